// File: rtl/sysarray_feed_sched.sv
// sysarray_feed_sched: row feeder for the triangular systolic array.
// Accepts one N_DIM-element row per handshake and injects element i into
// lane i after i+1 register stages (diagonal skew). Counts rows, flushes
// the skew tail plus DRAIN_CYC cycles, then pulses done_o for one cycle.
// freeze_i stalls everything and masks the outputs.
// Build option SYSARRAY_FEED_ZERO_PAD_EN: while busy and not frozen, all
// lanes present valid tokens and bubbles become zero-valued tokens.
//
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_STREAM | accepting rows until rows_cfg_q have been taken
// ST_FLUSH  | draining the skew tail plus DRAIN_CYC cycles
// ST_DONE   | one-cycle done pulse (held while frozen)
module sysarray_feed_sched #(
  parameter int N_DIM     = 3,
  parameter int DW        = 32,
  parameter int RW        = 8,
  parameter int DRAIN_CYC = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  freeze_i,
  input  logic                  start_i,
  input  logic [RW-1:0]         cfg_rows_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_DIM*DW-1:0]   in_data_i,
  output logic [N_DIM-1:0]      lane_valid_o,
  output logic [N_DIM*DW-1:0]   lane_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int FLUSH_LEN = N_DIM + DRAIN_CYC;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rows_cfg_q, rows_cfg_d;
  logic [RW-1:0]   rows_acc_q, rows_acc_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            accept;

  logic [N_DIM-1:0]    tail_v;
  logic [N_DIM*DW-1:0] tail_d;

  // Ready only counts against the row total captured at start.
  assign in_ready_o = (state_q == ST_STREAM) && !freeze_i && (rows_acc_q < rows_cfg_q);
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
  assign done_o     = (state_q == ST_DONE) && !freeze_i;

  // Control state register; freeze holds everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rows_cfg_q  <= '0;
      rows_acc_q  <= '0;
      flush_cnt_q <= '0;
    end else if (!freeze_i) begin
      state_q     <= state_d;
      rows_cfg_q  <= rows_cfg_d;
      rows_acc_q  <= rows_acc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic: row counting and flush down-counter.
  always_comb begin
    state_d     = state_q;
    rows_cfg_d  = rows_cfg_q;
    rows_acc_d  = rows_acc_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rows_cfg_d = cfg_rows_i;
          rows_acc_d = '0;
          state_d    = (cfg_rows_i == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          rows_acc_d = rows_acc_q + 1'b1;
          if (rows_acc_d == rows_cfg_q) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FW'(FLUSH_LEN - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_DONE;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One skew line per lane: lane g has g+1 stages.
  for (genvar g = 0; g < N_DIM; g++) begin : g_lane
    logic [g:0]    v_q;
    logic [DW-1:0] d_q [0:g];

    // Shift a token (or a zero bubble when nothing is accepted) each unfrozen cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_q <= '0;
        for (int s = 0; s <= g; s++) d_q[s] <= '0;
      end else if (!freeze_i) begin
        v_q[0] <= accept;
        d_q[0] <= accept ? in_data_i[g*DW +: DW] : '0;
        for (int s = g; s >= 1; s--) begin
          v_q[s] <= v_q[s-1];
          d_q[s] <= d_q[s-1];
        end
      end
    end

    assign tail_v[g]            = v_q[g];
    assign tail_d[g*DW +: DW]   = d_q[g];
  end

  // Lane outputs: masked by freeze, data forced to 0 whenever not a real token.
  always_comb begin
    lane_valid_o = '0;
    lane_data_o  = '0;
    for (int i = 0; i < N_DIM; i++) begin
      if (!freeze_i) begin
`ifdef SYSARRAY_FEED_ZERO_PAD_EN
        if (busy_o) begin
          lane_valid_o[i] = 1'b1;
          if (tail_v[i]) lane_data_o[i*DW +: DW] = tail_d[i*DW +: DW];
        end
`else
        if (tail_v[i]) begin
          lane_valid_o[i]         = 1'b1;
          lane_data_o[i*DW +: DW] = tail_d[i*DW +: DW];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sysarray_feed_sched.sv
module tb_sysarray_feed_sched;

  typedef struct packed {
    logic        rst;
    logic        frz;
    logic        st;
    logic [7:0]  cfg;
    logic        iv;
    logic [15:0] e2;
    logic [15:0] e1;
    logic [15:0] e0;
  } stim_t;

  typedef struct packed {
    logic        rdy;
    logic        bsy;
    logic        dn;
    logic [2:0]  lv;
    logic [15:0] d2;
    logic [15:0] d1;
    logic [15:0] d0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, freeze, start, in_valid;
  logic [7:0]  cfg_rows;
  logic [47:0] in_data;
  logic        in_ready, busy, done;
  logic [2:0]  lane_valid;
  logic [47:0] lane_data;
  logic        in_ready2, busy2, done2;
  logic [2:0]  lane_valid2;
  logic [47:0] lane_data2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sysarray_feed_sched #(.N_DIM(3), .DW(16), .RW(8), .DRAIN_CYC(0)) dut (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .start_i(start),
    .cfg_rows_i(cfg_rows), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .lane_valid_o(lane_valid), .lane_data_o(lane_data),
    .busy_o(busy), .done_o(done)
  );

  sysarray_feed_sched #(.N_DIM(3), .DW(16), .RW(8), .DRAIN_CYC(2)) dut_drain (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .start_i(start),
    .cfg_rows_i(cfg_rows), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .in_data_i(in_data), .lane_valid_o(lane_valid2), .lane_data_o(lane_data2),
    .busy_o(busy2), .done_o(done2)
  );

  task automatic apply(input stim_t x);
    rst      = x.rst;
    freeze   = x.frz;
    start    = x.st;
    cfg_rows = x.cfg;
    in_valid = x.iv;
    in_data  = {x.e2, x.e1, x.e0};
  endtask

  task automatic test_reset();
    stim_t s [5];
    exp_t  e [5];
    exp_t  o;
    s = '{'{1,0,1,2,1,3,2,1}, '{1,0,1,2,1,3,2,1}, '{1,1,0,0,1,6,5,4},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    for (int c = 0; c < 5; c++) e[c] = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [8];
    exp_t  e [8];
    exp_t  o;
    s = '{'{0,0,1,2,0,0,0,0}, '{0,0,0,0,1,3,2,1}, '{0,0,0,0,1,6,5,4}, '{0,0,0,0,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0}, '{1,1,0,3'b001,0,0,1},
          '{0,1,0,3'b011,0,2,4}, '{0,1,0,3'b110,3,5,0}, '{0,1,0,3'b100,6,0,0},
          '{0,0,1,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_gap();
    stim_t s [10];
    exp_t  e [10];
    exp_t  o;
    s = '{'{0,0,1,3,0,0,0,0}, '{0,0,0,0,1,9,8,7}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,1,12,11,10},
          '{0,0,0,0,1,15,14,13}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0}, '{1,1,0,3'b001,0,0,7},
          '{1,1,0,3'b010,0,8,0}, '{1,1,0,3'b101,9,0,10}, '{0,1,0,3'b011,0,11,13},
          '{0,1,0,3'b110,12,14,0}, '{0,1,0,3'b100,15,0,0}, '{0,0,1,3'b000,0,0,0},
          '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL gap cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_freeze();
    stim_t s [11];
    exp_t  e [11];
    exp_t  o;
    s = '{'{0,0,1,2,0,0,0,0}, '{0,0,0,0,1,3,2,1}, '{0,1,0,0,1,6,5,4}, '{0,1,0,0,1,6,5,4},
          '{0,0,0,0,1,6,5,4}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
          '{0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0}, '{0,1,0,3'b000,0,0,0},
          '{0,1,0,3'b000,0,0,0}, '{1,1,0,3'b001,0,0,1}, '{0,1,0,3'b011,0,2,4},
          '{0,1,0,3'b110,3,5,0}, '{0,1,0,3'b100,6,0,0}, '{0,0,0,3'b000,0,0,0},
          '{0,0,1,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL freeze cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_zero_rows_and_ignored_start();
    stim_t s [11];
    exp_t  e [11];
    exp_t  o;
    s = '{'{0,1,1,2,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,1,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
          '{0,0,1,1,0,0,0,0}, '{0,0,1,5,1,3,2,1}, '{0,0,1,5,1,9,9,9}, '{0,0,1,5,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0},
          '{0,0,1,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0},
          '{0,1,0,3'b001,0,0,1}, '{0,1,0,3'b010,0,2,0}, '{0,1,0,3'b100,3,0,0},
          '{0,0,1,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL zero_rows_start cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_rst_mid_flush();
    stim_t s [8];
    exp_t  e [8];
    exp_t  o;
    s = '{'{0,0,1,2,0,0,0,0}, '{0,0,0,0,1,3,2,1}, '{0,0,0,0,1,6,5,4}, '{0,0,0,0,0,0,0,0},
          '{1,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0}, '{1,1,0,3'b001,0,0,1},
          '{0,1,0,3'b011,0,2,4}, '{0,1,0,3'b110,3,5,0}, '{0,0,0,3'b000,0,0,0},
          '{0,0,0,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL rst_mid_flush cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_drain();
    stim_t s [10];
    exp_t  e [10];
    exp_t  o;
    s = '{'{0,0,1,2,0,0,0,0}, '{0,0,0,0,1,3,2,1}, '{0,0,0,0,1,6,5,4}, '{0,0,0,0,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b000,0,0,0}, '{1,1,0,3'b001,0,0,1},
          '{0,1,0,3'b011,0,2,4}, '{0,1,0,3'b110,3,5,0}, '{0,1,0,3'b100,6,0,0},
          '{0,1,0,3'b000,0,0,0}, '{0,1,0,3'b000,0,0,0}, '{0,0,1,3'b000,0,0,0},
          '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready2, busy2, done2, lane_valid2, lane_data2[47:32], lane_data2[31:16], lane_data2[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL drain cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  task automatic test_zero_pad();
    stim_t s [8];
    exp_t  e [8];
    exp_t  o;
    s = '{'{0,0,1,2,0,0,0,0}, '{0,0,0,0,1,3,2,1}, '{0,0,0,0,1,6,5,4}, '{0,0,0,0,0,0,0,0},
          '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}};
    e = '{'{0,0,0,3'b000,0,0,0}, '{1,1,0,3'b111,0,0,0}, '{1,1,0,3'b111,0,0,1},
          '{0,1,0,3'b111,0,2,4}, '{0,1,0,3'b111,3,5,0}, '{0,1,0,3'b111,6,0,0},
          '{0,0,1,3'b000,0,0,0}, '{0,0,0,3'b000,0,0,0}};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; apply(s[c]);
      @(negedge clk);
      o = '{in_ready, busy, done, lane_valid, lane_data[47:32], lane_data[31:16], lane_data[15:0]};
      checks++;
      if (o !== e[c]) begin
        failures++;
        $display("FAIL zero_pad cyc=%0d got=%h exp=%h", c, o, e[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; start = 1'b0; in_valid = 1'b0;
    cfg_rows = '0; in_data = '0;
    test_reset();
`ifdef SYSARRAY_FEED_ZERO_PAD_EN
    test_zero_pad();
`else
    test_back_to_back();
    test_gap();
    test_freeze();
    test_zero_rows_and_ignored_start();
    test_rst_mid_flush();
    test_drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
